// File: rtl/vec_l2_normalize.sv
// vec_l2_normalize: streaming L2 vector normalizer.
// Collects VEC_LEN signed Q16.16 elements and accumulates a saturating sum
// of squares. It sends one request to the inverse-sqrt unit and waits for the
// reply. It then emits every element scaled by 1/||v||.
// Optional feature: define VEC_NORM_TIMEOUT_EN to abort WAIT after TIMEOUT
// cycles. An aborted vector is emitted as zeros and the sticky err flag is set.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready/in_data   element input stream (Q16.16)
//   isq_valid/isq_x             request pulse and sum of squares to inverse-sqrt
//   isq_done/isq_y              reply from inverse-sqrt (1/sqrt(isq_x))
//   out_valid/out_ready         normalized element output stream
//   out_data/out_last/out_zero  element, end-of-vector marker, zero-sum marker
//   err                         sticky WAIT timeout flag
module vec_l2_normalize #(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        isq_valid,
    output logic [31:0] isq_x,
    input  logic        isq_done,
    input  logic [31:0] isq_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_zero,
    output logic        err
);
    localparam int unsigned      IDX_W    = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);
    localparam logic [31:0]      SAT_MAX  = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      acc;
    logic [31:0]      scale;
    logic [31:0]      elem_buf [VEC_LEN];

`ifdef VEC_NORM_TIMEOUT_EN
    localparam int unsigned       TCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
    logic [TCNT_W-1:0] tcnt;
`endif

    // Datapath: square of the incoming element, its saturating sum, and the
    // two Q16.16 products that feed out_data.
    logic [63:0]      sq_full;
    logic [31:0]      sq_sat;
    logic [31:0]      acc_sum;
    logic [31:0]      acc_next;
    logic [IDX_W-1:0] idx_inc;
    logic [63:0]      first_p;
    logic [63:0]      emit_p;

    assign sq_full  = {{32{in_data[31]}}, in_data} * {{32{in_data[31]}}, in_data};
    assign sq_sat   = (|sq_full[63:47]) ? SAT_MAX : sq_full[47:16];
    // Both operands are <= 0x7FFF_FFFF, so bit 31 of the sum flags overflow.
    assign acc_sum  = acc + sq_sat;
    assign acc_next = acc_sum[31] ? SAT_MAX : acc_sum;
    assign idx_inc  = idx + IDX_W'(1);
    // First output uses the reply directly since scale is loaded on the same edge.
    assign first_p  = {{32{elem_buf[0][31]}}, elem_buf[0]} * {{32{isq_y[31]}}, isq_y};
    assign emit_p   = {{32{elem_buf[idx_inc][31]}}, elem_buf[idx_inc]}
                    * {{32{scale[31]}}, scale};

    // Product bits outside the Q16.16 window are intentionally dropped.
    logic unused_ok;
    assign unused_ok = ^{sq_full[15:0], first_p[63:48], first_p[15:0],
                         emit_p[63:48], emit_p[15:0], 1'(TIMEOUT == 0)};

    // Element buffer: no reset needed, every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            elem_buf[idx] <= in_data;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_COLLECT;
            idx       <= '0;
            acc       <= '0;
            scale     <= '0;
            in_ready  <= 1'b1;
            isq_valid <= 1'b0;
            isq_x     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
            err       <= 1'b0;
`ifdef VEC_NORM_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            isq_valid <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (in_valid && in_ready) begin
                        acc <= acc_next;
                        err <= 1'b0;
                        if (idx == IDX_LAST) begin
                            idx      <= '0;
                            in_ready <= 1'b0;
                            if (acc_next == '0) begin
                                // Zero-length vector: skip inverse-sqrt, emit zeros.
                                scale     <= '0;
                                out_valid <= 1'b1;
                                out_data  <= '0;
                                out_last  <= 1'b0;
                                out_zero  <= 1'b1;
                                state     <= S_EMIT;
                            end else begin
                                isq_valid <= 1'b1;
                                isq_x     <= acc_next;
                                state     <= S_ISSUE;
                            end
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef VEC_NORM_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                S_WAIT: begin
                    if (isq_done) begin
                        scale     <= isq_y;
                        out_valid <= 1'b1;
                        out_data  <= first_p[47:16];
                        out_last  <= 1'b0;
                        out_zero  <= 1'b0;
                        state     <= S_EMIT;
                    end
`ifdef VEC_NORM_TIMEOUT_EN
                    else if (tcnt == TCNT_LAST) begin
                        err       <= 1'b1;
                        scale     <= '0;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        out_zero  <= 1'b0;
                        state     <= S_EMIT;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
`endif
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (idx == IDX_LAST) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            out_zero  <= 1'b0;
                            in_ready  <= 1'b1;
                            idx       <= '0;
                            acc       <= '0;
                            state     <= S_COLLECT;
                        end else begin
                            idx      <= idx_inc;
                            out_data <= emit_p[47:16];
                            out_last <= (idx_inc == IDX_LAST);
                        end
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_l2_normalize.sv
// Self-checking bench for vec_l2_normalize (VEC_LEN=4, TIMEOUT=15).
// Expected output words are queued when a vector is sent and are checked
// against each output handshake.
module tb_vec_l2_normalize;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned TIMEOUT = 15;

    typedef logic [31:0] vec_t [VEC_LEN];
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        isq_valid;
    logic [31:0] isq_x;
    logic        isq_done = 1'b0;
    logic [31:0] isq_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_zero;
    logic        err;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   isq_pulses = 0;
    exp_t sb[$];

    vec_l2_normalize #(.VEC_LEN(VEC_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .isq_valid(isq_valid), .isq_x(isq_x),
        .isq_done(isq_done), .isq_y(isq_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_zero(out_zero), .err(err)
    );

    always #5 clk = ~clk;

    // Reference arithmetic in 64-bit integers.
    function automatic logic [31:0] m_sq(input logic [31:0] x);
        longint sx;
        longint p;
        sx = longint'($signed(x));
        p  = sx * sx;
        if (p >= (longint'(1) <<< 47)) return 32'h7FFF_FFFF;
        return 32'(p >>> 16);
    endfunction

    function automatic logic [31:0] m_sumsq(input vec_t v);
        longint s;
        s = 0;
        for (int i = 0; i < VEC_LEN; i++) s += longint'(m_sq(v[i]));
        if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
        return 32'(s);
    endfunction

    function automatic logic [31:0] m_qmult(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb_;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        return 32'((sa * sb_) >>> 16);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input vec_t v, input logic [31:0] y);
        logic [31:0] s;
        exp_t        e;
        s = m_sumsq(v);
        for (int i = 0; i < VEC_LEN; i++) begin
            e.data = (s == 0) ? 32'h0 : m_qmult(v[i], y);
            e.last = (i == VEC_LEN - 1);
            e.zero = (s == 0);
            sb.push_back(e);
        end
    endtask

    // Sends one vector; returns at the cycle after the last accept.
    task automatic send_vector(input vec_t v);
        int k;
        for (int i = 0; i < VEC_LEN; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            k = 0;
            while (!in_ready && k < 100) begin
                cyc();
                k++;
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout in_ready=%b required=1", in_ready);
                break;
            end
            cyc();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Drains the current vector until in_ready comes back, then checks the queue.
    task automatic drain(input bit random_ready);
        int k;
        k = 0;
        while (!in_ready && k < 200) begin
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            k++;
        end
        out_ready = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain in_ready=%b pending=%0d required in_ready=1 pending=0",
                     in_ready, sb.size());
        end
        sb.delete();
    endtask

    // Output monitor: scoreboard pop, stall stability, no input overlap, zero idle data.
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (isq_valid === 1'b1) isq_pulses++;
        if (!rst) begin
            if (out_valid === 1'b1) begin
                if (prev_stall) begin
                    n_checks++;
                    if (out_data !== prev_data || out_last !== prev_last) begin
                        n_fail++;
                        $display("FAIL stall_stable data=%h last=%b required data=%h last=%b",
                                 out_data, out_last, prev_data, prev_last);
                    end
                end
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_overlap in_ready=%b required=0", in_ready);
                end
                if (out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_output data=%h last=%b required none", out_data, out_last);
                    end else begin
                        e = sb.pop_front();
                        if (out_data !== e.data || out_last !== e.last || out_zero !== e.zero) begin
                            n_fail++;
                            $display("FAIL out_word got=%h/%b/%b required=%h/%b/%b",
                                     out_data, out_last, out_zero, e.data, e.last, e.zero);
                        end
                    end
                end
            end else begin
                n_checks++;
                if (out_data !== 32'h0) begin
                    n_fail++;
                    $display("FAIL idle_data out_data=%h required=0", out_data);
                end
            end
        end
        prev_stall = !rst && (out_valid === 1'b1) && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, isq_valid, isq_x, out_valid, out_data, out_last, out_zero, err}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state in_ready=%b isq_valid=%b isq_x=%h out_valid=%b out_data=%h err=%b required 1/0/0/0/0/0",
                     in_ready, isq_valid, isq_x, out_valid, out_data, err);
        end
    endtask

    task automatic test_basic();
        vec_t v;
        int   p0;
        exp_t e;
        v = '{32'h0003_0000, 32'h0004_0000, 32'h0, 32'h0};
        e = '{32'h0000_9999, 1'b0, 1'b0}; sb.push_back(e);
        e = '{32'h0000_CCCC, 1'b0, 1'b0}; sb.push_back(e);
        e = '{32'h0000_0000, 1'b0, 1'b0}; sb.push_back(e);
        e = '{32'h0000_0000, 1'b1, 1'b0}; sb.push_back(e);
        p0 = isq_pulses;
        send_vector(v);
        n_checks++;
        if (isq_valid !== 1'b1 || isq_x !== 32'h0019_0000) begin
            n_fail++;
            $display("FAIL basic_issue isq_valid=%b isq_x=%h required 1/00190000", isq_valid, isq_x);
        end
        for (int i = 0; i < 6; i++) cyc();
        isq_done = 1'b1;
        isq_y    = 32'h0000_3333;
        cyc();
        isq_done = 1'b0;
        isq_y    = '0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_out_latency out_valid=%b required=1", out_valid);
        end
        drain(1'b0);
        n_checks++;
        if (isq_pulses - p0 != 1) begin
            n_fail++;
            $display("FAIL basic_pulse_count pulses=%0d required=1", isq_pulses - p0);
        end
    endtask

    task automatic test_zero_vector();
        vec_t v;
        int   p0;
        v = '{32'h0, 32'h0, 32'h0, 32'h0};
        push_model(v, 32'h0);
        p0 = isq_pulses;
        send_vector(v);
        n_checks++;
        if (out_valid !== 1'b1 || isq_valid !== 1'b0 || out_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_latency out_valid=%b isq_valid=%b out_zero=%b required 1/0/1",
                     out_valid, isq_valid, out_zero);
        end
        drain(1'b0);
        n_checks++;
        if (isq_pulses != p0) begin
            n_fail++;
            $display("FAIL zero_no_issue pulses=%0d required=0", isq_pulses - p0);
        end
    endtask

    task automatic test_backpressure();
        vec_t        v;
        logic [31:0] y;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < VEC_LEN; i++)
                v[i] = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            v[0] = 32'h0002_0000;
            y = 32'($urandom_range(32'h0000_1000, 32'h0001_0000));
            push_model(v, y);
            send_vector(v);
            n_checks++;
            if (isq_valid !== 1'b1 || isq_x !== m_sumsq(v)) begin
                n_fail++;
                $display("FAIL bp_issue isq_valid=%b isq_x=%h required 1/%h", isq_valid, isq_x, m_sumsq(v));
            end
            cyc();
            cyc();
            isq_done = 1'b1;
            isq_y    = y;
            cyc();
            isq_done = 1'b0;
            drain(1'b1);
        end
    endtask

    task automatic test_saturation();
        vec_t v;
        v = '{32'h0100_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0};
        push_model(v, 32'h0000_0100);
        send_vector(v);
        n_checks++;
        if (isq_valid !== 1'b1 || isq_x !== 32'h7FFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_isq_x isq_x=%h required=7fffffff", isq_x);
        end
        cyc();
        isq_done = 1'b1;
        isq_y    = 32'h0000_0100;
        cyc();
        isq_done = 1'b0;
        drain(1'b0);
    endtask

    task automatic test_reset_mid_wait();
        vec_t v;
        bit   bad;
        v = '{32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0};
        send_vector(v);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || isq_x !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wait_state in_ready=%b out_valid=%b isq_x=%h required 1/0/0",
                     in_ready, out_valid, isq_x);
        end
        cyc();
        isq_done = 1'b1;
        isq_y    = 32'h0000_3333;
        cyc();
        isq_done = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
            cyc();
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_stale_reply out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

`ifdef VEC_NORM_TIMEOUT_EN
    task automatic test_timeout();
        vec_t v;
        exp_t e;
        v = '{32'h0003_0000, 32'h0004_0000, 32'h0, 32'h0};
        for (int i = 0; i < VEC_LEN; i++) begin
            e = '{32'h0, (i == VEC_LEN - 1), 1'b0};
            sb.push_back(e);
        end
        send_vector(v);
        for (int i = 0; i < TIMEOUT; i++) cyc();
        n_checks++;
        if (err !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early err=%b out_valid=%b required 0/0", err, out_valid);
        end
        cyc();
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_fire err=%b out_valid=%b required 1/1", err, out_valid);
        end
        drain(1'b0);
        in_valid = 1'b1;
        in_data  = 32'h0;
        cyc();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear err=%b required=0", err);
        end
        for (int i = 1; i < VEC_LEN; i++) cyc();
        in_valid = 1'b0;
        for (int i = 0; i < VEC_LEN; i++) begin
            e = '{32'h0, (i == VEC_LEN - 1), 1'b1};
            sb.push_back(e);
        end
        drain(1'b0);
    endtask
`else
    task automatic test_no_timeout();
        vec_t v;
        v = '{32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000};
        push_model(v, 32'h0000_B505);
        send_vector(v);
        for (int i = 0; i < 40; i++) cyc();
        n_checks++;
        if (out_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout out_valid=%b err=%b required 0/0", out_valid, err);
        end
        isq_done = 1'b1;
        isq_y    = 32'h0000_B505;
        cyc();
        isq_done = 1'b0;
        drain(1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_vector();
        test_backpressure();
        test_saturation();
        test_reset_mid_wait();
        test_basic();
`ifdef VEC_NORM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_basic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
